// File: rtl/seq_div8.sv
// Multi-cycle restoring divider: one shift/subtract/test per clock, with signed
// magnitude pre-processing, a sign-fix cycle, and divide-by-zero / overflow flags.
module seq_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sgn,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             OV
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
        return -v;
    endfunction

    // In signed mode a negative operand is replaced by its magnitude; the
    // most negative value maps onto itself, which reads correctly as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             negq_q;
    logic             negr_q;
    logic             dbz_pend_q;
    logic             ov_pend_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic             ov_q;

    logic [WIDTH+1:0] trial_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // A negative trial implies the shifted remainder was below the divisor,
    // so dropping its top bit on restore loses nothing.
    always_comb begin
        trial_d = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
        rem_d   = trial_d[WIDTH+1] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial_d[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial_d[WIDTH+1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dbz_pend_q  <= 1'b0;
            ov_pend_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (strt) begin
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        negq_q    <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        negr_q    <= sgn & dividend[WIDTH-1];
                        dvs_q     <= magnitude(divisor, sgn);
                        quo_q     <= magnitude(dividend, sgn);
                        ov_pend_q <= sgn && (dividend == MIN_NEG) && (divisor == ALL_ONES);
                        if (divisor == '0) begin
                            rem_q      <= dividend;
                            dbz_pend_q <= 1'b1;
                            state_q    <= FIX;
                        end else begin
                            rem_q      <= '0;
                            dbz_pend_q <= 1'b0;
                            state_q    <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    if (dbz_pend_q) begin
                        quotient_q  <= ALL_ONES;
                        remainder_q <= rem_q;
                        dbz_q       <= 1'b1;
                        ov_q        <= 1'b0;
                    end else begin
                        quotient_q  <= negq_q ? negate(quo_q) : quo_q;
                        remainder_q <= negr_q ? negate(rem_q) : rem_q;
                        dbz_q       <= 1'b0;
                        ov_q        <= ov_pend_q;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign OV        = ov_q;

endmodule

// File: tb/tb_seq_div8.sv
// Directed-vector bench for seq_div8: hand-computed results for unsigned,
// signed, divide-by-zero, overflow, handshake and asynchronous-reset cases.
module tb_seq_div8;

    logic       clk;
    logic       rst_n;
    logic       strt;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       sgn;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;
    logic       OV;

    int checks;
    int failures;

    seq_div8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt      (strt),
        .dividend  (dividend),
        .divisor   (divisor),
        .sgn       (sgn),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .OV        (OV)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0; strt = 1'b0; dividend = 8'h00; divisor = 8'h00; sgn = 1'b0;
        #2;
        checks++;
        if (quotient !== 8'h00 || remainder !== 8'h00 || busy !== 1'b0 ||
            done !== 1'b0 || dbz !== 1'b0 || OV !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: q=%h r=%h busy=%b done=%b dbz=%b OV=%b, required all zero",
                     quotient, remainder, busy, done, dbz, OV);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_unsigned();
        logic [7:0] a [4];
        logic [7:0] b [4];
        logic [7:0] eq [4];
        logic [7:0] er [4];
        a  = '{8'd200, 8'd255, 8'd7, 8'd144};
        b  = '{8'd7,   8'd1,   8'd9, 8'd12};
        eq = '{8'd28,  8'd255, 8'd0, 8'd12};
        er = '{8'd4,   8'd0,   8'd7, 8'd0};
        for (int i = 0; i < 4; i++) begin
            dividend = a[i]; divisor = b[i]; sgn = 1'b0; strt = 1'b1;
            @(posedge clk); #1;
            strt = 1'b0; dividend = 8'hAA; divisor = 8'h55;
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL unsigned_busy[%0d]: busy=%b, required 1", i, busy);
            end
            repeat (8) @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL unsigned_early_done[%0d]: done=%b, required 0", i, done);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || quotient !== eq[i] || remainder !== er[i] ||
                dbz !== 1'b0 || OV !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL unsigned_result[%0d]: done=%b q=%h r=%h dbz=%b OV=%b busy=%b, required 1 %h %h 0 0 0",
                         i, done, quotient, remainder, dbz, OV, busy, eq[i], er[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || quotient !== eq[i] || remainder !== er[i]) begin
                failures++;
                $display("FAIL unsigned_hold[%0d]: done=%b q=%h r=%h, required 0 %h %h",
                         i, done, quotient, remainder, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] a [6];
        logic [7:0] b [6];
        logic [7:0] eq [6];
        logic [7:0] er [6];
        logic       eo [6];
        a  = '{8'h9C, 8'h64, 8'hF9, 8'h64, 8'h80, 8'h80};
        b  = '{8'h07, 8'hF9, 8'h02, 8'h07, 8'h01, 8'hFF};
        eq = '{8'hF2, 8'hF2, 8'hFD, 8'h0E, 8'h80, 8'h80};
        er = '{8'hFE, 8'h02, 8'hFF, 8'h02, 8'h00, 8'h00};
        eo = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        for (int i = 0; i < 6; i++) begin
            dividend = a[i]; divisor = b[i]; sgn = 1'b1; strt = 1'b1;
            @(posedge clk); #1;
            strt = 1'b0; dividend = 8'h33; divisor = 8'h00; sgn = 1'b0;
            repeat (9) @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || quotient !== eq[i] || remainder !== er[i] ||
                dbz !== 1'b0 || OV !== eo[i]) begin
                failures++;
                $display("FAIL signed_result[%0d]: done=%b q=%h r=%h dbz=%b OV=%b, required 1 %h %h 0 %b",
                         i, done, quotient, remainder, dbz, OV, eq[i], er[i], eo[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_by_zero();
        dividend = 8'd55; divisor = 8'd0; sgn = 1'b0; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0; dividend = 8'd1; divisor = 8'd1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL dbz_accept: busy=%b done=%b, required 1 0", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'hFF || remainder !== 8'd55 ||
            dbz !== 1'b1 || OV !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dbz_result: done=%b q=%h r=%h dbz=%b OV=%b busy=%b, required 1 ff 37 1 0 0",
                     done, quotient, remainder, dbz, OV, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || dbz !== 1'b1) begin
            failures++;
            $display("FAIL dbz_hold: done=%b dbz=%b, required 0 1", done, dbz);
        end
        dividend = 8'hFB; divisor = 8'h00; sgn = 1'b1; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'hFF || remainder !== 8'hFB || dbz !== 1'b1) begin
            failures++;
            $display("FAIL dbz_signed: done=%b q=%h r=%h dbz=%b, required 1 ff fb 1",
                     done, quotient, remainder, dbz);
        end
        @(posedge clk); #1;
        dividend = 8'd10; divisor = 8'd3; sgn = 1'b0; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        repeat (9) @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'd3 || remainder !== 8'd1 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL dbz_clear: done=%b q=%h r=%h dbz=%b, required 1 03 01 0",
                     done, quotient, remainder, dbz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        dividend = 8'h80; divisor = 8'hFF; sgn = 1'b1; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        repeat (9) @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'h80 || remainder !== 8'h00 || OV !== 1'b1) begin
            failures++;
            $display("FAIL ov_signed: done=%b q=%h r=%h OV=%b, required 1 80 00 1",
                     done, quotient, remainder, OV);
        end
        @(posedge clk); #1;
        dividend = 8'h80; divisor = 8'hFF; sgn = 1'b0; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        repeat (9) @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'h00 || remainder !== 8'h80 || OV !== 1'b0) begin
            failures++;
            $display("FAIL ov_unsigned: done=%b q=%h r=%h OV=%b, required 1 00 80 0",
                     done, quotient, remainder, OV);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        dividend = 8'd200; divisor = 8'd7; sgn = 1'b0; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        repeat (3) @(posedge clk); #1;
        dividend = 8'd9; divisor = 8'd2; sgn = 1'b1; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_mid: busy=%b, required 1", busy);
        end
        repeat (5) @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4) begin
            failures++;
            $display("FAIL b2b_ignored_strt: done=%b q=%h r=%h, required 1 1c 04",
                     done, quotient, remainder);
        end
        dividend = 8'd250; divisor = 8'd11; sgn = 1'b0; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept_on_done: busy=%b done=%b, required 1 0", busy, done);
        end
        repeat (8) @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || quotient !== 8'd28) begin
            failures++;
            $display("FAIL b2b_second_early: done=%b q=%h, required 0 1c", done, quotient);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'd22 || remainder !== 8'd8) begin
            failures++;
            $display("FAIL b2b_second_result: done=%b q=%h r=%h, required 1 16 08",
                     done, quotient, remainder);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_queue: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_async_reset();
        dividend = 8'd100; divisor = 8'd3; sgn = 1'b0; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (quotient !== 8'h00 || remainder !== 8'h00 || busy !== 1'b0 ||
            done !== 1'b0 || dbz !== 1'b0 || OV !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: q=%h r=%h busy=%b done=%b dbz=%b OV=%b, required all zero",
                     quotient, remainder, busy, done, dbz, OV);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL async_no_done[%0d]: done=%b busy=%b, required 0 0", i, done, busy);
            end
        end
        dividend = 8'd255; divisor = 8'd16; sgn = 1'b0; strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        repeat (9) @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'd15 || remainder !== 8'd15) begin
            failures++;
            $display("FAIL async_fresh_op: done=%b q=%h r=%h, required 1 0f 0f",
                     done, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_div8.md
Name: seq_div8

Overview:
- Multi-cycle 8-bit integer divider: the inverse operation of the team's 8-bit add/sub datapath.
- Implemented as a restoring shift/subtract loop: one subtract-and-test per clock, built from the same subtract and overflow rules as the adder.
- Sits beside the arithmetic block in the ALU cluster; issued via a start/done handshake by the controller.
- Supports unsigned and two's-complement signed division with divide-by-zero and signed-overflow flags.

Parameters:
- WIDTH, 8, operand/result width; must be ≥2. All text below assumes 8.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- strt  input  1  start request; sampled on rising clk
- dividend  input  8  numerator, captured when strt accepted
- divisor  input  8  denominator, captured when strt accepted
- sgn  input  1  1 = signed two's-complement operation, 0 = unsigned; captured with operands
- quotient  output  8  result quotient, registered
- remainder  output  8  result remainder, registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results are valid
- dbz  output  1  divide-by-zero flag for the last result
- OV  output  1  signed overflow flag for the last result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; quotient, remainder, busy, done, dbz and OV are all 0; internal registers cleared.
- Reset asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE, DIV, FIX.
- IDLE, strt=1 at edge E0:
  - Capture operands and sgn; busy=1 after E0.
  - Signed mode: take magnitudes |dividend| and |divisor|; latch sign_q = dividend[7]^divisor[7] and sign_r = dividend[7].
  - Clear iteration counter; go to DIV.
- Divide by zero (divisor==0 at capture): go straight to FIX, skipping DIV. In FIX: quotient=8'hFF, remainder=dividend unmodified, dbz=1, OV=0. done is high during the cycle after E1.
- DIV (edges E1..E8, exactly 8 iterations):
  - Shift the {partial remainder, quotient} pair left one bit.
  - Compute trial = partial remainder − divisor magnitude at 9-bit width.
  - If trial is non-negative, keep trial and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Counter reaches 7 on E8, then go to FIX.
- FIX (edge E9):
  - Apply sign correction: negate quotient if sign_q; negate remainder if sign_r. Signed division truncates toward zero; remainder takes the dividend's sign.
  - Load quotient/remainder outputs; set dbz=0.
  - OV=1 only for signed −128/−1: quotient=8'h80, remainder=0.
  - done=1 for exactly one cycle after E9; busy drops at E9; go to IDLE.
- Latency: 9 clocks from the strt-accept edge to results valid (1 clock for divide-by-zero).
- Outputs and flags hold their values until the next completion.
- strt while busy is ignored; no queuing.
- strt in the same cycle as done (state already IDLE) is accepted; back-to-back operation is allowed.
- Unsigned mode never sets OV.
- Operands may change after capture without effect.

Test Plan:
- Unsigned 200/7, sgn=0 -> after 9 clocks quotient=28 (8'h1C), remainder=4, done pulses 1 cycle, OV=0, dbz=0.
- Signed −100/7 (8'h9C/8'h07), sgn=1 -> quotient=−14 (8'hF2), remainder=−2 (8'hFE); also check 100/−7 -> 8'hF2, 8'h02.
- Divide by zero: 55/0 -> done one cycle after strt, quotient=8'hFF, remainder=55, dbz=1; then 10/3 clears dbz (quotient=3, remainder=1).
- Signed −128/−1 -> quotient=8'h80, remainder=0, OV=1; unsigned 128/255 -> quotient=0, remainder=128, OV=0.
- strt pulsed again at cycle 4 of an operation with different operands -> ignored, first result unaffected; strt on the done cycle -> second operation starts and completes 9 clocks later.
- rst_n dropped asynchronously mid-DIV -> all outputs 0 immediately, no done pulse; after release a fresh 255/16 gives quotient=15, remainder=15.
